// File: rtl/lsd_frame_sequencer.sv
// Frame sequencer for the LSD filter pipeline: free-running raster counters, one-frame capture, drain and done.
// Optional LSD_SEQ_UNDERRUN_CNT_EN adds a saturating per-frame underrun pixel counter.
module lsd_frame_sequencer #(
  parameter int BIT_WIDTH    = -1,
  parameter int IMAGE_HEIGHT = -1,
  parameter int IMAGE_WIDTH  = -1,
  parameter int FRAME_HEIGHT = -1,
  parameter int FRAME_WIDTH  = -1,
  parameter int PIPE_LATENCY = -1,
  localparam int V_BITW = $clog2(FRAME_HEIGHT),
  localparam int H_BITW = $clog2(FRAME_WIDTH)
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun,
  input  logic                 src_valid,
  input  logic [BIT_WIDTH-1:0] src_pixel,
  output logic                 src_ready,
  output logic [BIT_WIDTH-1:0] out_pixel,
  output logic [V_BITW-1:0]    out_vcnt,
  output logic [H_BITW-1:0]    out_hcnt
`ifdef LSD_SEQ_UNDERRUN_CNT_EN
  ,output logic [15:0]         underrun_count
`endif
);

  localparam int D_BITW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY + 1) : 1;
  localparam logic [V_BITW-1:0] V_LAST = V_BITW'(FRAME_HEIGHT - 1);
  localparam logic [H_BITW-1:0] H_LAST = H_BITW'(FRAME_WIDTH - 1);
  // one extra bit: the image may fill the whole power-of-two counter range
  localparam logic [V_BITW:0]   V_IMG  = (V_BITW + 1)'(IMAGE_HEIGHT);
  localparam logic [H_BITW:0]   H_IMG  = (H_BITW + 1)'(IMAGE_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [V_BITW-1:0]    cv_q, cv_d;
  logic [H_BITW-1:0]    ch_q, ch_d;
  logic [V_BITW-1:0]    out_vcnt_q;
  logic [H_BITW-1:0]    out_hcnt_q;
  logic [BIT_WIDTH-1:0] out_pixel_q, out_pixel_d;
  logic [D_BITW-1:0]    drain_q, drain_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 at_last, active, und_hit, und_clr;

  always_comb begin
    at_last = (cv_q == V_LAST) && (ch_q == H_LAST);
    active  = ({1'b0, cv_q} < V_IMG) && ({1'b0, ch_q} < H_IMG);
    ch_d    = (ch_q == H_LAST) ? '0 : ch_q + H_BITW'(1);
    cv_d    = cv_q;
    if (ch_q == H_LAST) cv_d = (cv_q == V_LAST) ? '0 : cv_q + V_BITW'(1);

    state_d     = state_q;
    drain_d     = drain_q;
    done_d      = 1'b0;
    out_pixel_d = '0;
    und_hit     = 1'b0;
    und_clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          und_clr = 1'b1;
          state_d = at_last ? S_CAPTURE : S_ARMED;
        end
      end
      S_ARMED: begin
        if (at_last) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (active) begin
          if (src_valid) out_pixel_d = src_pixel;
          else           und_hit     = 1'b1;
        end
        if (at_last) begin
          state_d = S_DRAIN;
          drain_d = D_BITW'(PIPE_LATENCY);
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q - D_BITW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      cv_q        <= '0;
      ch_q        <= '0;
      out_vcnt_q  <= '0;
      out_hcnt_q  <= '0;
      out_pixel_q <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cv_q        <= cv_d;
      ch_q        <= ch_d;
      out_vcnt_q  <= cv_q;
      out_hcnt_q  <= ch_q;
      out_pixel_q <= out_pixel_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef LSD_SEQ_UNDERRUN_CNT_EN
  logic [15:0] und_cnt_q, und_cnt_d;

  always_comb begin
    und_cnt_d = und_cnt_q;
    if (und_clr)                           und_cnt_d = '0;
    else if (und_hit && (und_cnt_q != '1)) und_cnt_d = und_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) und_cnt_q <= '0;
    else        und_cnt_q <= und_cnt_d;
  end

  assign underrun_count = und_cnt_q;
  assign underrun       = (und_cnt_q != '0);
`else
  logic und_q, und_d;

  always_comb begin
    und_d = und_q;
    if (und_clr)      und_d = 1'b0;
    else if (und_hit) und_d = 1'b1;
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) und_q <= 1'b0;
    else        und_q <= und_d;
  end

  assign underrun = und_q;
`endif

  assign src_ready = (state_q == S_CAPTURE) && active;
  assign out_pixel = out_pixel_q;
  assign out_vcnt  = out_vcnt_q;
  assign out_hcnt  = out_hcnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lsd_frame_sequencer.sv
// Bench for lsd_frame_sequencer: edge-indexed frame model checked every cycle, plus hand-computed literals.
module tb_lsd_frame_sequencer;
  localparam int BW = 8, IH = 4, IW = 6, FH = 6, FW = 8, PL = 15;
  localparam int FP = FH * FW;

  logic          clock = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          src_valid = 1'b0;
  logic [BW-1:0] src_pixel = '0;
  logic          busy, done, underrun, src_ready;
  logic [BW-1:0] out_pixel;
  logic [2:0]    out_vcnt;
  logic [2:0]    out_hcnt;
`ifdef LSD_SEQ_UNDERRUN_CNT_EN
  logic [15:0]   underrun_count;
`endif

  lsd_frame_sequencer #(
    .BIT_WIDTH(BW), .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW),
    .FRAME_HEIGHT(FH), .FRAME_WIDTH(FW), .PIPE_LATENCY(PL)
  ) dut (
    .clock(clock), .n_rst(n_rst), .start(start), .busy(busy), .done(done),
    .underrun(underrun), .src_valid(src_valid), .src_pixel(src_pixel),
    .src_ready(src_ready), .out_pixel(out_pixel), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt)
`ifdef LSD_SEQ_UNDERRUN_CNT_EN
    , .underrun_count(underrun_count)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: e counts clock edges since reset; the raster position sampled at edge e is (e-1) mod FP.
  int e = 0, acc_e = 0, e0 = 0, done_e = 0, ucnt = 0, mc = 0, nc = 0;
  bit act = 0, und = 0, cap = 0, actv = 0;
  int exp_v = 0, exp_h = 0, exp_pix = 0;
  bit exp_done = 0, exp_busy = 0, exp_rdy = 0;

  always @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      e = 0; act = 0; acc_e = 0; e0 = 0; done_e = 0; und = 0; ucnt = 0;
      exp_v = 0; exp_h = 0; exp_pix = 0; exp_done = 0; exp_busy = 0; exp_rdy = 0;
    end else begin
      e = e + 1;
      mc = (e - 1) % FP;
      if (start && (!act || e > done_e)) begin
        act = 1; acc_e = e; und = 0; ucnt = 0;
        e0 = e + 1;
        while (((e0 - 1) % FP) != 0) e0++;
        done_e = e0 + FP - 1 + PL + 1;
      end
      cap  = act && e >= e0 && e <= e0 + FP - 1;
      actv = (mc / FW) < IH && (mc % FW) < IW;
      exp_pix = (cap && actv && src_valid) ? int'(src_pixel) : 0;
      if (cap && actv && !src_valid) begin
        und = 1;
        if (ucnt < 65535) ucnt++;
      end
      exp_v    = mc / FW;
      exp_h    = mc % FW;
      exp_done = act && e == done_e;
      exp_busy = act && e >= acc_e && e < done_e;
      nc = e % FP;
      exp_rdy = act && (e + 1) >= e0 && (e + 1) <= e0 + FP - 1 && (nc / FW) < IH && (nc % FW) < IW;
    end
  end

  always @(negedge clock) begin
    if (n_rst) begin
      chk("vcnt", int'(out_vcnt), exp_v);
      chk("hcnt", int'(out_hcnt), exp_h);
      chk("pixel", int'(out_pixel), exp_pix);
      chk("done", int'(done), int'(exp_done));
      chk("busy", int'(busy), int'(exp_busy));
      chk("src_ready", int'(src_ready), int'(exp_rdy));
      chk("underrun", int'(underrun), int'(und));
`ifdef LSD_SEQ_UNDERRUN_CNT_EN
      chk("underrun_count", int'(underrun_count), ucnt);
`endif
    end
  end

  int next_pix = 1;

  // Parked at a negedge: drive inputs, then advance to the next negedge.
  task automatic cyc(input bit st, input bit v);
    start = st; src_valid = v; src_pixel = next_pix[BW-1:0];
    @(negedge clock);
  endtask

  task automatic run_frame(input bit hold, input int dlo, input int dhi,
                           output int rdy_n, output int first_rdy, output int gap,
                           output int pix_first, output int pix_last);
    int lastpos;
    bit fin, vld;
    rdy_n = 0; first_rdy = -1; gap = -1; pix_first = -1; pix_last = -1;
    lastpos = -1; fin = 0; next_pix = 1;
    for (int i = 0; i < 300 && !fin; i++) begin
      if (rdy_n == 24 && lastpos < 0 && out_vcnt == 3'd5 && out_hcnt == 3'd7) lastpos = i;
      if (rdy_n >= 1 && pix_first < 0 && out_vcnt == 3'd0 && out_hcnt == 3'd0) pix_first = int'(out_pixel);
      if (rdy_n == 24 && pix_last < 0 && out_vcnt == 3'd3 && out_hcnt == 3'd5) pix_last = int'(out_pixel);
      if (i > 0 && done) begin
        gap = (lastpos < 0) ? -1 : i - lastpos;
        fin = 1;
        cyc(hold, 1'b0);
      end else begin
        vld = !(src_ready && rdy_n >= dlo && rdy_n <= dhi);
        start = (i == 0) || hold;
        src_valid = vld;
        src_pixel = next_pix[BW-1:0];
        if (src_ready) begin
          if (first_rdy < 0) first_rdy = i;
          if (vld) next_pix++;
          rdy_n++;
        end
        @(negedge clock);
      end
    end
    if (!fin) chk("frame_timeout", 0, 1);
  endtask

  int rn, fr, gp, pf, plst, dn;

  initial begin
    repeat (3) @(negedge clock);
    #2 n_rst = 1'b1;
    #1;
    chk("rst_vcnt", int'(out_vcnt), 0);
    chk("rst_hcnt", int'(out_hcnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pixel", int'(out_pixel), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_underrun", int'(underrun), 0);
    @(negedge clock);

    // free-running raster wraps at (5,7)
    while (e < 48) cyc(1'b0, 1'b0);
    chk("wrap_last_v", int'(out_vcnt), 5);
    chk("wrap_last_h", int'(out_hcnt), 7);
    cyc(1'b0, 1'b0);
    chk("wrap_zero_v", int'(out_vcnt), 0);
    chk("wrap_zero_h", int'(out_hcnt), 0);

    // start mid-frame at counter (2,3)
    while (e % FP != 19) cyc(1'b0, 1'b0);
    run_frame(1'b0, -1, -1, rn, fr, gp, pf, plst);
    chk("mid_ready_cycles", rn, 24);
    chk("mid_first_ready", fr, 29);
    chk("mid_pix_first", pf, 1);
    chk("mid_pix_last", plst, 24);
    chk("mid_done_gap", gp, 16);
    chk("mid_underrun", int'(underrun), 0);
    chk("mid_busy_after", int'(busy), 0);

    // start exactly at LAST
    while (e % FP != 47) cyc(1'b0, 1'b0);
    run_frame(1'b0, -1, -1, rn, fr, gp, pf, plst);
    chk("last_first_ready", fr, 1);
    chk("last_ready_cycles", rn, 24);
    chk("last_done_gap", gp, 16);

    // underrun on three active pixels
    run_frame(1'b0, 5, 7, rn, fr, gp, pf, plst);
    chk("und_ready_cycles", rn, 24);
    chk("und_pix_first", pf, 1);
    chk("und_pix_last", plst, 21);
    chk("und_flag", int'(underrun), 1);
`ifdef LSD_SEQ_UNDERRUN_CNT_EN
    chk("und_count", int'(underrun_count), 3);
`endif
    cyc(1'b0, 1'b0);
    chk("und_sticky", int'(underrun), 1);

    // start held through a frame, re-accepted in the done cycle
    run_frame(1'b1, -1, -1, rn, fr, gp, pf, plst);
    chk("hold_ready_cycles", rn, 24);
    chk("hold_underrun_cleared", int'(underrun), 0);
    chk("b2b_busy", int'(busy), 1);
    run_frame(1'b0, -1, -1, rn, fr, gp, pf, plst);
    chk("b2b_first_ready", fr, 31);
    chk("b2b_ready_cycles", rn, 24);
    chk("b2b_pix_last", plst, 24);
    chk("b2b_done_gap", gp, 16);

    // reset while draining
    while (e % FP != 47) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (52) cyc(1'b0, 1'b1);
    chk("drain_busy_before", int'(busy), 1);
    #1 n_rst = 1'b0;
    #1;
    chk("drain_rst_busy", int'(busy), 0);
    chk("drain_rst_vcnt", int'(out_vcnt), 0);
    chk("drain_rst_hcnt", int'(out_hcnt), 0);
    chk("drain_rst_ready", int'(src_ready), 0);
    @(negedge clock);
    #2 n_rst = 1'b1;
    @(negedge clock);
    dn = 0;
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, 1'b0);
      if (done) dn++;
    end
    chk("drain_rst_no_done", dn, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsd_frame_sequencer.md
# lsd_frame_sequencer

Frame-level controller that sequences the LSD filter pipeline (gaussian and the following stages). It owns the free-running raster counters (`vcnt`/`hcnt`) the stream pipeline runs on. On `start` it gates exactly one frame of source pixels into the pipeline, aligned to raster (0,0). It then pulses `done` when the last coordinate of that frame exits the downstream pipeline, whose fixed latency is a parameter.

## Interface
- `BIT_WIDTH`, default -1: pixel width.
- `IMAGE_HEIGHT`, default -1: active rows.
- `IMAGE_WIDTH`, default -1: active columns.
- `FRAME_HEIGHT`, default -1: total rows including blanking; at least `IMAGE_HEIGHT`.
- `FRAME_WIDTH`, default -1: total columns including blanking; at least `IMAGE_WIDTH`.
- `PIPE_LATENCY`, default -1: downstream latency in cycles, at least 1 (gaussian = `FRAME_WIDTH`+7).
- `V_BITW` = log2(`FRAME_HEIGHT`) and `H_BITW` = log2(`FRAME_WIDTH`) are localparams, using the ceil-log2 function.

Ports:
- `clock` in 1: single clock.
- `n_rst` in 1: reset, asynchronous active-low.
- `start` in 1: request one frame; sampled while idle.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `underrun` out 1: sticky; a source pixel was missing during capture.
- `src_valid` in 1: source pixel available.
- `src_pixel` in `BIT_WIDTH`: source pixel.
- `src_ready` out 1: pixel consumed this cycle when `src_valid` is also high.
- `out_pixel` out `BIT_WIDTH`: to pipeline `in_pixel`.
- `out_vcnt` out `V_BITW`: to pipeline `in_vcnt`.
- `out_hcnt` out `H_BITW`: to pipeline `in_hcnt`.

## Operation
- **Raster counters (`cv`, `ch`)**
  - Free-running from reset, incrementing every cycle.
  - `ch` wraps at `FRAME_WIDTH`-1; `cv` increments on the `ch` wrap and itself wraps at `FRAME_HEIGHT`-1.
  - LAST = (`FRAME_HEIGHT`-1, `FRAME_WIDTH`-1).
- **Active region:** `cv` < `IMAGE_HEIGHT` and `ch` < `IMAGE_WIDTH`.
- **States:** IDLE, ARMED, CAPTURE, DRAIN.
- **IDLE**
  - `start` with counter = LAST goes to CAPTURE.
  - `start` otherwise goes to ARMED.
  - `start` in any state other than IDLE is ignored.
  - An accepted `start` clears `underrun`.
- **ARMED:** counter = LAST goes to CAPTURE, so CAPTURE always begins with counter (0,0).
- **CAPTURE**
  - `src_ready` = active region (combinational from state and counter).
  - In the active region:
    - with `src_valid` = 1, `out_pixel` <= `src_pixel`;
    - otherwise `out_pixel` <= 0 and `underrun` <= 1. The raster never stalls.
  - Outside the active region, `out_pixel` <= 0.
  - Counter = LAST goes to DRAIN, loading the drain counter with `PIPE_LATENCY`.
- **DRAIN**
  - The drain counter decrements each cycle.
  - On reaching 0: `done` <= 1, state goes to IDLE.
- **Outside CAPTURE:** `src_ready` = 0 and `out_pixel` <= 0.
- **Outputs:** `out_vcnt`/`out_hcnt` <= `cv`/`ch` every cycle, in every state.
- **`busy`** = state is not IDLE. It is registered and falls in the same cycle `done` rises.
- **Back-to-back frames:** a `start` in the `done` cycle is accepted (state is already IDLE).

## Timing
- **Reset values:** `cv`=`ch`=0, `out_vcnt`=`out_hcnt`=0, `out_pixel`=0, `busy`=0, `done`=0, `underrun`=0, state IDLE, drain counter 0.
- **Coordinate alignment:** `out_vcnt`/`out_hcnt` lag `cv`/`ch` by 1 cycle, and `out_pixel` is aligned with them.
- **Source latency:** a pixel accepted at edge k appears on `out_pixel` after edge k.
- **`done`:** asserted exactly `PIPE_LATENCY`+1 cycles after `out_vcnt`/`out_hcnt` = LAST for the captured frame. This is the cycle in which the pipeline output carries LAST.
- **Start-to-first-coordinate:** at most one frame period plus 1 cycle.
- **Reset mid-operation:** all state returns to reset values immediately; there is no `done` pulse.

## Configuration
- **`LSD_SEQ_UNDERRUN_CNT_EN` defined**
  - Adds output `underrun_count` [15:0]: saturating count of underrun pixels in the current frame.
  - Cleared on accepted `start`; reset value 0.
  - `underrun` = (`underrun_count` != 0).
- **Not defined:** the port is absent and only the sticky `underrun` flag exists.

## Test plan
All scenarios use IMAGE 4x6, FRAME 6x8, `PIPE_LATENCY`=15 (frame period 48 cycles).
- **Reset:** release reset with `start`=0 → `out_vcnt`/`out_hcnt` step (0,0),(0,1)…(5,7),(0,0); `busy`=0; `out_pixel`=0; `src_ready` never high.
- **Start mid-frame:** `start` pulsed at counter (2,3), `src_valid`=1, pixels 1..24 → `src_ready` high for exactly 24 cycles starting at counter (0,0). `out_pixel` = 1..24 at `out` coordinates (0,0)…(3,5), and 0 elsewhere. `done` fires 16 cycles after `out` = (5,7). `underrun`=0.
- **Start at LAST:** `start` with counter = (5,7) → capture begins the next cycle with no ARMED frame.
- **Underrun:** `src_valid` dropped for 3 active cycles → those `out_pixel` values are 0, `underrun`=1 until the next accepted `start`. With the macro defined, `underrun_count`=3.
- **Ignored start, back-to-back:** `start` held during CAPTURE is ignored. `start` in the `done` cycle → ARMED, and the second frame starts at the next (0,0).
- **Reset in DRAIN:** assert `n_rst`=0 during DRAIN → `busy`=0 and counters 0 immediately; no `done` follows.
